reg_file_wb: RTL and testbench
==============================

# reg_file_wb

Register file with a registered write-back stage, sitting directly downstream of the 5-bit write-register select mux (rt/rd) in the single-cycle CPU datapath. It provides two combinational read ports (rs, rt) and one write port; write requests are captured into a one-entry pending write-back register and committed to the array on the following edge. A pending write is forwarded to the read ports when the addresses match. Register $0 is hardwired to zero.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth is 2**ADDR_W
- BYPASS, 1, 1 = forward pending write data to read ports; 0 = reads see array contents only
- CNT_W, 16, width of the commit counter

- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  reset, asynchronous, active-low
- RSaddr_i  input  ADDR_W  read port A address
- RTaddr_i  input  ADDR_W  read port B address
- RDaddr_i  input  ADDR_W  write address, driven by the write-register select mux
- RDdata_i  input  DATA_W  write data
- RegWrite_i  input  1  write request qualifier
- RSdata_o  output  DATA_W  read port A data, combinational
- RTdata_o  output  DATA_W  read port B data, combinational
- wb_pending_o  output  1  pending write-back entry valid
- commit_cnt_o  output  CNT_W  number of writes committed to the array since reset

## Operation
- State: array reg[0..2**ADDR_W-1], pend_valid, pend_addr, pend_data, commit counter.
- Capture (every rising edge):
  - pend_valid <= RegWrite_i && (RDaddr_i != 0).
  - pend_addr <= RDaddr_i and pend_data <= RDdata_i when that condition holds.
  - Writes to $0 are dropped: not captured, not counted.
- Commit (same edge): if pend_valid was 1 before the edge, reg[pend_addr] <= pend_data and the counter increments. Capture and commit happen on the same edge, so back-to-back writes sustain one write per cycle.
- Read, per port, priority order:
  1. Address 0 returns 0.
  2. If BYPASS=1, pend_valid=1 and the address equals pend_addr, return pend_data.
  3. Otherwise return reg[address].
- Consecutive writes to the same address: the newer pending entry is forwarded; the array receives the older value, then the newer one on the next edge.
- Read and write to the same address in the same cycle: the read returns the pre-capture value (pending or array). Data just presented on RDdata_i is never forwarded combinationally.
- Counter wraps from 2**CNT_W-1 to 0 with no flag.
- wb_pending_o = pend_valid.

## Timing
- Reset (rst_i low, asynchronous, independent of clk_i): all array entries 0, pend_valid 0, counter 0. Therefore RSdata_o=0, RTdata_o=0, wb_pending_o=0, commit_cnt_o=0.
- Reset asserted mid-operation discards the pending entry without committing it.
- First edge after rst_i rises performs normal capture.
- Write presented in cycle N:
  - pending and forwardable (BYPASS=1) from after edge N;
  - visible in the array, and via reads with BYPASS=0, from after edge N+1.
  - Write-to-array latency: 2 edges. Read latency: 0 cycles (combinational).
- commit_cnt_o increments after edge N+1 for a write captured at edge N.
- No stall or backpressure. Every qualified request is accepted.

## Test plan
- Reset: pulse rst_i low between edges -> all outputs 0 immediately, without a clock edge; reading any address returns 0.
- Single write, BYPASS=1: RegWrite_i=1, RDaddr_i=5, RDdata_i=0xDEADBEEF in cycle 0, then idle -> RSaddr_i=5 reads 0xDEADBEEF after edge 0; wb_pending_o is 1 in cycle 1 and 0 in cycle 2; commit_cnt_o=1 after edge 1.
- Same write with BYPASS=0 -> RSdata_o for address 5 stays 0 after edge 0 and reads 0xDEADBEEF after edge 1.
- $0 write: RegWrite_i=1, RDaddr_i=0, RDdata_i=0x1234 -> wb_pending_o stays 0, reads of address 0 return 0, commit_cnt_o unchanged.
- Back-to-back writes to the same address: reg 8 gets 0x1 then 0x2 on consecutive cycles -> read of 8 returns 0x1 after the first edge and 0x2 after the second; array holds 0x2 after the third edge; commit_cnt_o=2.
- Reset mid-flight: write reg 3 = 0xAA, assert rst_i before the commit edge -> after reset, reg 3 reads 0 and commit_cnt_o=0. Also check counter wrap with CNT_W=2: 5 writes -> commit_cnt_o=1.

Source files
------------

// File: rtl/reg_file_wb_if.sv
// Bus bundle for reg_file_wb: read/write addresses, write data and qualifier
// in one direction; read data, pending flag and commit counter in the other.
interface reg_file_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);

    logic [ADDR_W-1:0] RSaddr_i;
    logic [ADDR_W-1:0] RTaddr_i;
    logic [ADDR_W-1:0] RDaddr_i;
    logic [DATA_W-1:0] RDdata_i;
    logic              RegWrite_i;
    logic [DATA_W-1:0] RSdata_o;
    logic [DATA_W-1:0] RTdata_o;
    logic              wb_pending_o;
    logic [CNT_W-1:0]  commit_cnt_o;

    // Datapath side: issues addresses and write requests.
    modport master (
        output RSaddr_i,
        output RTaddr_i,
        output RDaddr_i,
        output RDdata_i,
        output RegWrite_i,
        input  RSdata_o,
        input  RTdata_o,
        input  wb_pending_o,
        input  commit_cnt_o
    );

    // Register file side.
    modport slave (
        input  RSaddr_i,
        input  RTaddr_i,
        input  RDaddr_i,
        input  RDdata_i,
        input  RegWrite_i,
        output RSdata_o,
        output RTdata_o,
        output wb_pending_o,
        output commit_cnt_o
    );

endinterface

// File: rtl/reg_file_wb.sv
// Register file with a one-entry registered write-back stage.
// Ports: clk_i, rst_i (async, active-low), bus (reg_file_wb_if.slave):
//   two combinational read ports (RS/RT), one write port (RD/RegWrite),
//   wb_pending_o = pending entry valid, commit_cnt_o = committed writes.
module reg_file_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    reg_file_wb_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] reg_q [DEPTH];
    logic [DATA_W-1:0] reg_d [DEPTH];

    logic              pend_valid_q;
    logic              pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q;
    logic [ADDR_W-1:0] pend_addr_d;
    logic [DATA_W-1:0] pend_data_q;
    logic [DATA_W-1:0] pend_data_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    // Capture: writes to $0 are dropped here, so the pending entry never
    // targets register 0 and the array's entry 0 stays at its reset value.
    always_comb begin
        pend_valid_d = bus.RegWrite_i && (bus.RDaddr_i != '0);
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        if (pend_valid_d) begin
            pend_addr_d = bus.RDaddr_i;
            pend_data_d = bus.RDdata_i;
        end
    end

    // Commit: the entry captured on the previous edge lands in the array.
    always_comb begin
        reg_d = reg_q;
        cnt_d = cnt_q;
        if (pend_valid_q) begin
            reg_d[pend_addr_q] = pend_data_q;
            cnt_d              = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i] <= '0;
            end
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            cnt_q        <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i] <= reg_d[i];
            end
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            cnt_q        <= cnt_d;
        end
    end

    // Reads use only registered state; RDdata_i is never forwarded
    // combinationally, so a same-cycle read sees the pre-capture value.
    always_comb begin
        rs_data = reg_q[bus.RSaddr_i];
        if (bus.RSaddr_i == '0) begin
            rs_data = '0;
        end else if (BYPASS && pend_valid_q
                     && (bus.RSaddr_i == pend_addr_q)) begin
            rs_data = pend_data_q;
        end
    end

    always_comb begin
        rt_data = reg_q[bus.RTaddr_i];
        if (bus.RTaddr_i == '0) begin
            rt_data = '0;
        end else if (BYPASS && pend_valid_q
                     && (bus.RTaddr_i == pend_addr_q)) begin
            rt_data = pend_data_q;
        end
    end

    assign bus.RSdata_o     = rs_data;
    assign bus.RTdata_o     = rt_data;
    assign bus.wb_pending_o = pend_valid_q;
    assign bus.commit_cnt_o = cnt_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: three instances (bypass, no bypass,
// 2-bit counter) share stimulus; a negedge monitor checks queued expectations.
module tb_reg_file_wb;

    logic clk;
    logic rst_n;

    reg_file_wb_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus_a ();
    reg_file_wb_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus_b ();
    reg_file_wb_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(2))  bus_c ();

    reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1), .CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_a)
    );

    reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0), .CNT_W(16)) dut_nb (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_b)
    );

    reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1), .CNT_W(2)) dut_w (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_A_RS  = 0;
    localparam int K_A_RT  = 1;
    localparam int K_A_PND = 2;
    localparam int K_A_CNT = 3;
    localparam int K_B_RS  = 4;
    localparam int K_C_CNT = 5;
    localparam int K_B_RT  = 6;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } chk_t;

    chk_t q[$];
    chk_t cur;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] act;

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_A_RS:  return bus_a.RSdata_o;
            K_A_RT:  return bus_a.RTdata_o;
            K_A_PND: return {31'b0, bus_a.wb_pending_o};
            K_A_CNT: return {16'b0, bus_a.commit_cnt_o};
            K_B_RS:  return bus_b.RSdata_o;
            K_B_RT:  return bus_b.RTdata_o;
            K_C_CNT: return {30'b0, bus_c.commit_cnt_o};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() != 0) begin
            cur = q.pop_front();
            act = actual(cur.kind);
            checks++;
            if (act !== cur.val) begin
                errors++;
                $display("FAIL %s: got %h want %h @%0t",
                         cur.name, act, cur.val, $time);
            end
        end
    end

    task automatic push(input int k, input logic [31:0] v,
                        input string n);
        chk_t c;
        c.kind = k;
        c.val  = v;
        c.name = n;
        q.push_back(c);
    endtask

    task automatic drive(input logic we, input logic [4:0] rd,
                         input logic [31:0] d, input logic [4:0] rs,
                         input logic [4:0] rt);
        bus_a.RegWrite_i = we; bus_a.RDaddr_i = rd; bus_a.RDdata_i = d;
        bus_a.RSaddr_i = rs;   bus_a.RTaddr_i = rt;
        bus_b.RegWrite_i = we; bus_b.RDaddr_i = rd; bus_b.RDdata_i = d;
        bus_b.RSaddr_i = rs;   bus_b.RTaddr_i = rt;
        bus_c.RegWrite_i = we; bus_c.RDaddr_i = rd; bus_c.RDdata_i = d;
        bus_c.RSaddr_i = rs;   bus_c.RTaddr_i = rt;
    endtask

    task automatic step(input logic we, input logic [4:0] rd,
                        input logic [31:0] d, input logic [4:0] rs,
                        input logic [4:0] rt);
        @(posedge clk);
        #1;
        drive(we, rd, d, rs, rt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd9);
        push(K_A_RS,  32'h0, "rst_rs");
        push(K_A_RT,  32'h0, "rst_rt");
        push(K_A_PND, 32'h0, "rst_pend");
        push(K_A_CNT, 32'h0, "rst_cnt");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // single write to r5
        step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        push(K_A_RS,  32'h0, "same_cycle_no_fwd");
        push(K_A_PND, 32'h0, "pend_before");
        push(K_B_RS,  32'h0, "nb_same_cycle");
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        push(K_A_RS,  32'hDEADBEEF, "bypass_fwd");
        push(K_A_PND, 32'h1, "pend_c1");
        push(K_A_CNT, 32'h0, "cnt_c1");
        push(K_B_RS,  32'h0, "nb_hidden");
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        push(K_A_RS,  32'hDEADBEEF, "array_r5");
        push(K_A_PND, 32'h0, "pend_c2");
        push(K_A_CNT, 32'h1, "cnt_c2");
        push(K_B_RS,  32'hDEADBEEF, "nb_visible");
        push(K_C_CNT, 32'h1, "w_cnt_c2");

        // write to $0 is dropped
        step(1'b1, 5'd0, 32'h1234, 5'd0, 5'd5);
        push(K_A_RS,  32'h0, "r0_read");
        push(K_A_RT,  32'hDEADBEEF, "rt_r5");
        step(1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
        push(K_A_PND, 32'h0, "zero_write_pend");
        push(K_A_CNT, 32'h1, "zero_write_cnt");
        push(K_A_RS,  32'h0, "zero_write_r0");

        // back-to-back writes to r8
        step(1'b1, 5'd8, 32'h1, 5'd8, 5'd0);
        push(K_A_RS,  32'h0, "b2b_pre");
        step(1'b1, 5'd8, 32'h2, 5'd8, 5'd0);
        push(K_A_RS,  32'h1, "b2b_first");
        push(K_A_PND, 32'h1, "b2b_pend");
        push(K_B_RS,  32'h0, "b2b_nb_first");
        step(1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
        push(K_A_RS,  32'h2, "b2b_second");
        push(K_A_RT,  32'h2, "b2b_second_rt");
        push(K_A_CNT, 32'h2, "b2b_cnt_mid");
        push(K_B_RS,  32'h1, "b2b_nb_older");
        push(K_B_RT,  32'h1, "b2b_nb_older_rt");
        step(1'b0, 5'd0, 32'h0, 5'd8, 5'd0);
        push(K_A_RS,  32'h2, "b2b_array");
        push(K_A_PND, 32'h0, "b2b_pend_clr");
        push(K_A_CNT, 32'h3, "b2b_cnt");
        push(K_B_RS,  32'h2, "b2b_nb_newer");

        // reset while r3 is still pending
        step(1'b1, 5'd3, 32'hAA, 5'd3, 5'd0);
        push(K_A_RS,  32'h0, "flight_pre");
        step(1'b0, 5'd0, 32'h0, 5'd3, 5'd8);
        #1 rst_n = 1'b0;
        push(K_A_RS,  32'h0, "async_rs");
        push(K_A_RT,  32'h0, "async_rt");
        push(K_A_PND, 32'h0, "async_pend");
        push(K_A_CNT, 32'h0, "async_cnt");
        push(K_B_RT,  32'h0, "async_nb_rt");
        push(K_C_CNT, 32'h0, "async_w_cnt");
        step(1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
        rst_n = 1'b1;
        push(K_A_RS,  32'h0, "flight_discard");
        push(K_B_RS,  32'h0, "flight_nb");
        push(K_A_CNT, 32'h0, "flight_cnt");
        push(K_A_PND, 32'h0, "flight_pend");

        // five writes; 2-bit counter wraps to 1
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 5'(i), 32'h10 + 32'(i), 5'(i - 1), 5'd0);
            if (i >= 2) begin
                push(K_A_RS, 32'h10 + 32'(i - 1), "burst_fwd");
                push(K_C_CNT, 32'((i - 2) % 4), "burst_w_cnt");
            end
        end
        step(1'b0, 5'd0, 32'h0, 5'd4, 5'd1);
        push(K_A_CNT, 32'h4, "burst_cnt4");
        push(K_C_CNT, 32'h0, "cnt_wrap_zero");
        push(K_B_RS,  32'h14, "burst_nb_r4");
        step(1'b0, 5'd0, 32'h0, 5'd4, 5'd1);
        push(K_A_CNT, 32'h5, "burst_cnt5");
        push(K_C_CNT, 32'h1, "cnt_wrap");
        push(K_B_RT,  32'h11, "burst_nb_r1");
        push(K_A_PND, 32'h0, "burst_pend_clr");

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d want 0 queued", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
